processing_element: RTL and testbench
=====================================

PROCESSING_ELEMENT -- requirements
Module: processing_element

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the signed width of the activation and weight.
REQ-002 The block SHALL have parameter ACC_W, default 24, giving the signed width of the partial sum (ACC_W >= 2*DATA_W).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port n_rst, input, 1: asynchronous, active-high reset; 1 = reset asserted, despite the name.
REQ-005 Port load_weight, input, 1: capture weight_in into the stationary weight register.
REQ-006 Port weight_in, input, DATA_W: signed weight from the PE above.
REQ-007 Port weight_out, output, DATA_W: registered copy of weight_in, for the PE below.
REQ-008 Port load_weight_out, output, 1: registered copy of load_weight.
REQ-009 Port act_in / act_valid_in, input, DATA_W / 1: signed activation from the left and its valid.
REQ-010 Port act_out / act_valid_out, output, DATA_W / 1: registered activation and valid, for the PE to the right.
REQ-011 Port psum_in, input, ACC_W: signed partial sum from the PE above.
REQ-012 Port psum_out / psum_valid_out, output, ACC_W / 1: registered partial sum and valid.
REQ-013 Port clear_ovf, input, 1: synchronous clear of the sticky overflow flag.
REQ-014 Port ovf, output, 1: sticky saturation flag.

Function
REQ-015 Latency SHALL be exactly 1 cycle from any input to its corresponding output; outputs SHALL be driven directly from registers.
REQ-016 On each edge: act_out <= act_in, act_valid_out <= act_valid_in, weight_out <= weight_in, load_weight_out <= load_weight, all unconditionally.
REQ-017 When load_weight=1, weight_reg <= weight_in; otherwise weight_reg SHALL hold its value.
REQ-018 When act_valid_in=1: psum_out <= sat(psum_in + act_in*weight_reg), a signed multiply sign-extended to ACC_W+1 bits before the add; psum_valid_out <= 1.
REQ-019 When act_valid_in=0: psum_out <= psum_in unchanged; psum_valid_out <= 0.
REQ-020 sat() SHALL clamp the result to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clamp SHALL set ovf on the same edge that psum_out updates.
REQ-021 ovf SHALL stay at 1 until clear_ovf=1; if a clamp and clear_ovf=1 occur in the same cycle, ovf SHALL be 1 (set wins).
REQ-022 If load_weight=1 and act_valid_in=1 occur in the same cycle, the MAC SHALL use the old weight_reg; the new weight applies from the next cycle.
REQ-023 act_in values SHALL be forwarded to act_out even when act_valid_in=0.

Reset
REQ-024 While n_rst=1, all registers SHALL be 0 immediately, independent of clk: weight_reg, weight_out, load_weight_out, act_out, act_valid_out, psum_out, psum_valid_out, ovf.
REQ-025 Reset asserted mid-operation SHALL discard the weight and any in-flight psum; after release, the first edge SHALL behave per REQ-016 to REQ-021 with weight_reg=0.

Structure
REQ-026 A shared package SHALL hold the DATA_W/ACC_W defaults and the typedefs act_t (signed DATA_W) and psum_t (signed ACC_W).
REQ-027 A single sub-module, sat_add, SHALL be used for the combinational (ACC_W+1)-to-ACC_W signed saturating add, with a clamp-indicator output; all remaining logic is flat registers.

Verification
REQ-028 Reset: assert n_rst=1 mid-clock -> all outputs read 0 before the next edge; release and idle 2 cycles -> outputs remain 0.
REQ-029 MAC: load weight 3, then act_in=-4 with act_valid_in=1 and psum_in=100 -> next cycle psum_out=88, psum_valid_out=1, act_out=-4.
REQ-030 Pass-through: act_valid_in=0, psum_in=1234 -> psum_out=1234, psum_valid_out=0, ovf=0.
REQ-031 Saturation: weight 127, act_in 127, psum_in=8388600 -> psum_out=8388607, ovf=1; hold ovf for 3 cycles, then clear_ovf=1 -> ovf=0.
REQ-032 Simultaneous load and MAC: weight_reg=2, load_weight=1 with weight_in=5, act_in=10 with act_valid_in=1, psum_in=0 -> psum_out=20; next MAC with act_in=10 -> psum_out=50.
REQ-033 Forwarding: a stream of 4 weights and activations -> weight_out, load_weight_out, act_out and act_valid_out reproduce the same stream delayed by exactly 1 cycle.

Source files
------------

// File: rtl/processing_element_pkg.sv
// Shared types and default widths for the systolic processing element.
// act_t/psum_t give the signed activation/weight and partial-sum shapes.
package processing_element_pkg;

    localparam int PE_DATA_W = 8;
    localparam int PE_ACC_W  = 24;

    typedef logic signed [PE_DATA_W-1:0] act_t;
    typedef logic signed [PE_ACC_W-1:0]  psum_t;

endpackage

// File: rtl/processing_element_sat_add.sv
// Signed saturating add: two (W+1)-bit operands, W-bit clamped result.
// Ports: i_a, i_b operands; o_sum clamped sum; o_clamp high when clamped.
module sat_add
    import processing_element_pkg::*;
#(
    parameter int W = PE_ACC_W
) (
    input  logic signed [W:0]   i_a,
    input  logic signed [W:0]   i_b,
    output logic signed [W-1:0] o_sum,
    output logic                o_clamp
);

    localparam logic signed [W+1:0] MAXV = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MINV = {3'b111, {(W-1){1'b0}}};

    logic signed [W+1:0] w_a_x;
    logic signed [W+1:0] w_b_x;
    logic signed [W+1:0] w_sum;
    logic                w_hi;
    logic                w_lo;

    // One guard bit so the add itself can never wrap.
    assign w_a_x = {i_a[W], i_a};
    assign w_b_x = {i_b[W], i_b};
    assign w_sum = w_a_x + w_b_x;

    assign w_hi = (w_sum > MAXV);
    assign w_lo = (w_sum < MINV);

    always_comb begin
        o_sum = w_sum[W-1:0];
        if (w_hi) begin
            o_sum = MAXV[W-1:0];
        end else if (w_lo) begin
            o_sum = MINV[W-1:0];
        end
    end

    assign o_clamp = w_hi | w_lo;

endmodule

// File: rtl/processing_element.sv
// Weight-stationary systolic PE: psum_out = sat(psum_in + act*weight).
// Ports: clk, n_rst (active-high async), weight/act/psum in/out, ovf flags.
module processing_element
    import processing_element_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int ACC_W  = PE_ACC_W
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     load_weight,
    input  logic signed [DATA_W-1:0] weight_in,
    output logic signed [DATA_W-1:0] weight_out,
    output logic                     load_weight_out,
    input  logic signed [DATA_W-1:0] act_in,
    input  logic                     act_valid_in,
    output logic signed [DATA_W-1:0] act_out,
    output logic                     act_valid_out,
    input  logic signed [ACC_W-1:0]  psum_in,
    output logic signed [ACC_W-1:0]  psum_out,
    output logic                     psum_valid_out,
    input  logic                     clear_ovf,
    output logic                     ovf
);

    localparam int PW = 2 * DATA_W;

    logic signed [DATA_W-1:0] r_weight;
    logic signed [DATA_W-1:0] r_weight_out;
    logic                     r_load_out;
    logic signed [DATA_W-1:0] r_act;
    logic                     r_act_valid;
    logic signed [ACC_W-1:0]  r_psum;
    logic                     r_psum_valid;
    logic                     r_ovf;

    logic signed [PW-1:0]     w_prod;
    logic signed [ACC_W:0]    w_prod_x;
    logic signed [ACC_W:0]    w_psum_x;
    logic signed [ACC_W-1:0]  w_sat;
    logic                     w_clamp;

    // Multiply uses the weight held before this edge, so a same-cycle
    // load only takes effect on the following MAC.
    assign w_prod   = act_in * r_weight;
    assign w_prod_x = {{(ACC_W+1-PW){w_prod[PW-1]}}, w_prod};
    assign w_psum_x = {psum_in[ACC_W-1], psum_in};

    sat_add #(
        .W (ACC_W)
    ) u_sat_add (
        .i_a     (w_psum_x),
        .i_b     (w_prod_x),
        .o_sum   (w_sat),
        .o_clamp (w_clamp)
    );

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_weight     <= '0;
            r_weight_out <= '0;
            r_load_out   <= 1'b0;
            r_act        <= '0;
            r_act_valid  <= 1'b0;
        end else begin
            if (load_weight) begin
                r_weight <= weight_in;
            end
            r_weight_out <= weight_in;
            r_load_out   <= load_weight;
            r_act        <= act_in;
            r_act_valid  <= act_valid_in;
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_psum       <= '0;
            r_psum_valid <= 1'b0;
        end else if (act_valid_in) begin
            r_psum       <= w_sat;
            r_psum_valid <= 1'b1;
        end else begin
            r_psum       <= psum_in;
            r_psum_valid <= 1'b0;
        end
    end

    // Sticky flag; a fresh clamp beats a simultaneous clear.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_ovf <= 1'b0;
        end else if (act_valid_in && w_clamp) begin
            r_ovf <= 1'b1;
        end else if (clear_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign weight_out      = r_weight_out;
    assign load_weight_out = r_load_out;
    assign act_out         = r_act;
    assign act_valid_out   = r_act_valid;
    assign psum_out        = r_psum;
    assign psum_valid_out  = r_psum_valid;
    assign ovf             = r_ovf;

endmodule

// File: tb/tb_processing_element.sv
// Randomized self-checking bench for processing_element.
// Reference model tracks weight and ovf with plain integer arithmetic.
module tb_processing_element;

    localparam int DW   = 8;
    localparam int AW   = 24;
    localparam longint PMAX = (64'sd1 <<< (AW-1)) - 1;
    localparam longint PMIN = -(64'sd1 <<< (AW-1));

    logic                 clk;
    logic                 n_rst;
    logic                 load_weight;
    logic signed [DW-1:0] weight_in;
    logic signed [DW-1:0] weight_out;
    logic                 load_weight_out;
    logic signed [DW-1:0] act_in;
    logic                 act_valid_in;
    logic signed [DW-1:0] act_out;
    logic                 act_valid_out;
    logic signed [AW-1:0] psum_in;
    logic signed [AW-1:0] psum_out;
    logic                 psum_valid_out;
    logic                 clear_ovf;
    logic                 ovf;

    int n_tests;
    int n_fail;

    longint m_w;
    longint m_ovf;

    processing_element #(
        .DATA_W (DW),
        .ACC_W  (AW)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .load_weight     (load_weight),
        .weight_in       (weight_in),
        .weight_out      (weight_out),
        .load_weight_out (load_weight_out),
        .act_in          (act_in),
        .act_valid_in    (act_valid_in),
        .act_out         (act_out),
        .act_valid_out   (act_valid_out),
        .psum_in         (psum_in),
        .psum_out        (psum_out),
        .psum_valid_out  (psum_valid_out),
        .clear_ovf       (clear_ovf),
        .ovf             (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".w"}, longint'(weight_out), 0);
        chk({tag, ".lw"}, longint'(load_weight_out), 0);
        chk({tag, ".a"}, longint'(act_out), 0);
        chk({tag, ".av"}, longint'(act_valid_out), 0);
        chk({tag, ".p"}, longint'(psum_out), 0);
        chk({tag, ".pv"}, longint'(psum_valid_out), 0);
        chk({tag, ".ovf"}, longint'(ovf), 0);
    endtask

    // One clock: drive at negedge, advance model, check #1 after posedge.
    task automatic cyc(input longint lw, input longint wi,
                       input longint ai, input longint av,
                       input longint pi, input longint co);
        longint s;
        longint e_p;
        longint e_pv;
        longint sat;
        @(negedge clk);
        load_weight  = lw[0];
        weight_in    = wi[DW-1:0];
        act_in       = ai[DW-1:0];
        act_valid_in = av[0];
        psum_in      = pi[AW-1:0];
        clear_ovf    = co[0];
        @(posedge clk);
        sat = 0;
        if (av != 0) begin
            s = pi + ai * m_w;
            e_pv = 1;
            if (s > PMAX) begin
                e_p = PMAX;
                sat = 1;
            end else if (s < PMIN) begin
                e_p = PMIN;
                sat = 1;
            end else begin
                e_p = s;
            end
        end else begin
            e_p  = pi;
            e_pv = 0;
        end
        if (sat != 0) m_ovf = 1;
        else if (co != 0) m_ovf = 0;
        if (lw != 0) m_w = wi;
        #1;
        chk("weight_out", longint'(weight_out), wi);
        chk("load_out", longint'(load_weight_out), lw);
        chk("act_out", longint'(act_out), ai);
        chk("act_valid_out", longint'(act_valid_out), av);
        chk("psum_out", longint'(psum_out), e_p);
        chk("psum_valid", longint'(psum_valid_out), e_pv);
        chk("ovf", longint'(ovf), m_ovf);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b1;
        m_w   = 0;
        m_ovf = 0;
        @(negedge clk);
        n_rst = 1'b0;
    endtask

    initial begin
        logic signed [DW-1:0] rw;
        logic signed [DW-1:0] ra;
        logic signed [AW-1:0] rp;
        longint pv;
        n_tests      = 0;
        n_fail       = 0;
        m_w          = 0;
        m_ovf        = 0;
        n_rst        = 1'b1;
        load_weight  = 1'b0;
        weight_in    = '0;
        act_in       = '0;
        act_valid_in = 1'b0;
        psum_in      = '0;
        clear_ovf    = 1'b0;
        #12;
        n_rst = 1'b0;
        chk_zero("por");

        // MAC: w=3, act=-4, psum=100 -> 88
        cyc(1, 3, 0, 0, 0, 0);
        cyc(0, 0, -4, 1, 100, 0);
        chk("mac.88", longint'(psum_out), 88);
        chk("mac.act", longint'(act_out), -4);

        // Pass-through
        cyc(0, 0, 7, 0, 1234, 0);
        chk("pass.1234", longint'(psum_out), 1234);

        // Saturation, sticky hold, then clear
        cyc(1, 127, 0, 0, 0, 0);
        cyc(0, 0, 127, 1, 8388600, 0);
        chk("sat.max", longint'(psum_out), 8388607);
        chk("sat.ovf", longint'(ovf), 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 5, 0);
        chk("sat.hold", longint'(ovf), 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("sat.clr", longint'(ovf), 0);

        // Negative saturation with simultaneous clear: set wins
        cyc(0, 0, -128, 1, -8388600, 1);
        chk("satn.min", longint'(psum_out), -8388608);
        chk("satn.ovf", longint'(ovf), 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Simultaneous load and MAC uses old weight
        cyc(1, 2, 0, 0, 0, 0);
        cyc(1, 5, 10, 1, 0, 0);
        chk("ldmac.20", longint'(psum_out), 20);
        cyc(0, 0, 10, 1, 0, 0);
        chk("ldmac.50", longint'(psum_out), 50);

        // Forwarding stream
        cyc(1, 11, -3, 1, 0, 0);
        cyc(0, -22, 33, 0, 0, 0);
        cyc(1, 44, -55, 1, 0, 0);
        cyc(0, -66, 77, 0, 0, 0);

        // Reset mid-clock clears everything at once
        @(posedge clk);
        #2;
        n_rst = 1'b1;
        m_w   = 0;
        m_ovf = 0;
        #1;
        chk_zero("arst");
        @(negedge clk);
        n_rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk_zero("idle");
        cyc(0, 0, 9, 1, 17, 0);
        chk("post_rst.w0", longint'(psum_out), 17);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rw = DW'($urandom);
            ra = DW'($urandom);
            rp = AW'($urandom);
            pv = longint'(rp);
            if ($urandom_range(0, 3) == 0) begin
                pv = ($urandom_range(0, 1) != 0) ?
                     PMAX - $urandom_range(0, 20000) :
                     PMIN + $urandom_range(0, 20000);
            end
            if (i == 200) do_reset();
            cyc($urandom_range(0, 3) == 0, longint'(rw),
                longint'(ra), $urandom_range(0, 3) != 0,
                pv, $urandom_range(0, 7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
